usb2_token_crc5_check: RTL
==========================

# usb2_token_crc5_check

Receive-side checker for USB 2.0 token packets, the counterpart of the 4-bit parallel CRC5 generator. It accepts the 16-bit token body (ADDR[6:0], ENDP[3:0], CRC5[4:0]) as four 4-bit nibbles over a valid/ready handshake. It runs the CRC5 over all 16 bits and compares the remainder against the USB residual. It then presents the decoded address, endpoint and a pass/fail flag on a result handshake to the token decoder downstream.

## Interface
- RESET_SEED, 5'h1F: CRC register value at each start of token.
- RESIDUE, 5'h0C: remainder expected after all 16 bits when the CRC is good.
- CLK  in  1  single clock, rising edge.
- RSTn  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous abort: return to IDLE and drop any partial or held token.
- nib_valid  in  1  nibble offered.
- nib_sop  in  1  qualifies nib_valid: this is nibble 0 of a token.
- nib_in  in  4  token bits; nib_in[0] is the earliest bit on the wire.
- nib_ready  out  1  nibble accepted when nib_valid && nib_ready.
- res_valid  out  1  result held.
- res_ready  in  1  result consumed when res_valid && res_ready.
- res_addr  out  7  token ADDR.
- res_endp  out  4  token ENDP.
- res_crc_ok  out  1  1 if the final remainder equals RESIDUE.
- err_cnt  out  8  CRC failures; present only with USB2_CRC5_ERRCNT_EN.

## Operation
- Token word W[15:0] = {CRC5, ENDP, ADDR}. Nibble k carries W[4k+3:4k].
- Per-bit update, applied for nib_in[0], then [1], [2], [3]:
  - fb = b ^ crc[4]
  - crc = {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000)
- States:
  - IDLE: nib_ready=1. A nibble with nib_sop=1 loads crc from the update of RESET_SEED, stores the nibble, sets cnt=1 and moves to COLLECT. A nibble with nib_sop=0 is accepted and discarded.
  - COLLECT: nib_ready=1. An accepted nibble with nib_sop=0 updates crc and is stored at position cnt. When cnt reaches 3, the state moves to DONE.
    - An accepted nibble with nib_sop=1 restarts the token: the partial token is dropped, crc is reseeded and cnt=1.
  - DONE: res_valid=1, nib_ready=0. The result fields stay stable until res_ready. The handshake returns the block to IDLE.
- res_crc_ok = (crc == RESIDUE), registered on entry to DONE.
- clear has priority over everything except RSTn.
- Reset values: state IDLE, crc=RESET_SEED, cnt=0, nib_ready=1, res_valid=0, res_addr=0, res_endp=0, res_crc_ok=0, err_cnt=0.

## Timing
- res_valid rises on the clock edge after the 4th nibble is accepted. Minimum token-to-result latency is 4 accept cycles + 1.
- Throughput: one token every 5 cycles when res_ready is tied high. No new nibble is accepted in the DONE cycle.
- nib_ready depends on state only, never combinationally on nib_valid.
- res_valid is not combinationally dependent on res_ready.
- If clear is asserted together with the 4th nibble, the token is dropped and res_valid stays 0.
- If clear is asserted in DONE, res_valid falls on the next edge. The result is lost and err_cnt does not update.
- Asynchronous RSTn mid-token forces every output to its reset value immediately. No result is produced for that token.

## Configuration
- USB2_CRC5_ERRCNT_EN defined:
  - err_cnt port exists.
  - err_cnt increments by 1 on each entry to DONE with res_crc_ok=0.
  - err_cnt saturates at 8'hFF.
  - clear does not reset err_cnt; only RSTn does.
- Not defined: the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Package usb2_crc_pkg holds:
  - CRC5 polynomial constant 5'b00101, seed 5'h1F and residue 5'h0C.
  - Token field widths (7, 4, 5).
  - State encoding IDLE/COLLECT/DONE.
- Sub-module usb2_crc5_nibble_step: purely combinational. Inputs crc_in[4:0] and nib[3:0]; output crc_out[4:0], the four-bit unrolled update. The generator also uses this sub-module.
- The top contains the FSM, the nibble counter, the 12-bit data capture and the optional error counter.

## Test plan
- Good token 1: after reset, nibbles 5(sop),1,F,B, i.e. ADDR=0x15, ENDP=0xE, CRC5=0x17. Expected: res_valid on the edge after nibble 3, res_addr=0x15, res_endp=0xE, res_crc_ok=1.
- Good tokens 2 and 3, back-to-back with res_ready=1:
  - ADDR=0x3A, ENDP=0xA, CRC5=0x1C -> res_crc_ok=1.
  - ADDR=0x70, ENDP=0x4, CRC5=0x0E -> res_crc_ok=1.
  - Expected: each result 5 cycles apart.
- Corrupted token: token 1 with the last nibble 0xA instead of 0xB. Expected: res_crc_ok=0, and err_cnt=1 when USB2_CRC5_ERRCNT_EN is defined.
- Restart: nibbles 5(sop),1, then a new sop with token 2. Expected: exactly one result, for ADDR=0x3A.
- Backpressure and clear:
  - Hold res_ready=0 for 10 cycles. Expected: nib_ready=0 throughout, result stable, only one result delivered.
  - Separately, pulse clear with the 4th nibble. Expected: no res_valid.
- Reset mid-token: drop RSTn after 2 nibbles. Expected: all outputs return to reset values asynchronously, and the next full good token passes.

Source files
------------

// File: rtl/usb2_crc_pkg.sv
// +----------------------------------------------------------------------+
// | usb2_crc_pkg : shared CRC5 constants, token field widths, FSM states |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package usb2_crc_pkg;

  localparam logic [4:0] CRC5_POLY  = 5'b00101;
  localparam logic [4:0] RESET_SEED = 5'h1F;
  localparam logic [4:0] RESIDUE    = 5'h0C;

  localparam int ADDR_W = 7;
  localparam int ENDP_W = 4;
  localparam int CRC_W  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } tok_state_e;

endpackage

`default_nettype wire

// File: rtl/usb2_crc5_nibble_step.sv
// +----------------------------------------------------------------------+
// | usb2_crc5_nibble_step : CRC5 advanced by four bits, nib[0] first     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module usb2_crc5_nibble_step
  import usb2_crc_pkg::*;
(
  input  logic [4:0] crc_in,
  input  logic [3:0] nib,
  output logic [4:0] crc_out
);

  logic [4:0] w_c;

  always_comb begin
    w_c = crc_in;
    for (int i = 0; i < 4; i++) begin
      w_c = {w_c[3:0], 1'b0} ^ (((nib[i] ^ w_c[4]) == 1'b1) ? CRC5_POLY : 5'b00000);
    end
    crc_out = w_c;
  end

endmodule

`default_nettype wire

// File: rtl/usb2_token_crc5_check.sv
// +----------------------------------------------------------------------+
// | usb2_token_crc5_check : USB 2.0 token CRC5 receive checker           |
// | Optional error counter: USB2_CRC5_ERRCNT_EN. Rev 1.0                 |
// +----------------------------------------------------------------------+
`default_nettype none

module usb2_token_crc5_check
  import usb2_crc_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              clear,
  input  logic              nib_valid,
  input  logic              nib_sop,
  input  logic [3:0]        nib_in,
  output logic              nib_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic [ENDP_W-1:0] res_endp,
  output logic              res_crc_ok
`ifdef USB2_CRC5_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  tok_state_e        state_q;
  logic [4:0]        crc_q;
  logic [1:0]        cnt_q;
  logic [11:0]       data_q;
  logic              nib_ready_q;
  logic              res_valid_q;
  logic [ADDR_W-1:0] res_addr_q;
  logic [ENDP_W-1:0] res_endp_q;
  logic              res_crc_ok_q;

  logic       w_nib_acc;
  logic       w_reseed;
  logic       w_last;
  logic [4:0] w_step_in;
  logic [4:0] crc_d;

  assign w_nib_acc = nib_valid & nib_ready_q;
  // A token start (from IDLE or a mid-token restart) always steps from the seed.
  assign w_reseed  = (state_q == IDLE) | nib_sop;
  assign w_step_in = w_reseed ? RESET_SEED : crc_q;
  assign w_last    = w_nib_acc & (state_q == COLLECT) & ~nib_sop & (cnt_q == 2'd3);

  usb2_crc5_nibble_step u_step (
    .crc_in  (w_step_in),
    .nib     (nib_in),
    .crc_out (crc_d)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      crc_q        <= RESET_SEED;
      cnt_q        <= 2'd0;
      data_q       <= 12'h000;
      nib_ready_q  <= 1'b1;
      res_valid_q  <= 1'b0;
      res_addr_q   <= '0;
      res_endp_q   <= '0;
      res_crc_ok_q <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      crc_q       <= RESET_SEED;
      cnt_q       <= 2'd0;
      nib_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_nib_acc && nib_sop) begin
            crc_q       <= crc_d;
            data_q[3:0] <= nib_in;
            cnt_q       <= 2'd1;
            state_q     <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_nib_acc && nib_sop) begin
            crc_q       <= crc_d;
            data_q[3:0] <= nib_in;
            cnt_q       <= 2'd1;
          end else if (w_last) begin
            // ADDR and ENDP lie entirely within the first three nibbles.
            crc_q        <= crc_d;
            cnt_q        <= 2'd0;
            state_q      <= DONE;
            nib_ready_q  <= 1'b0;
            res_valid_q  <= 1'b1;
            res_addr_q   <= data_q[6:0];
            res_endp_q   <= data_q[10:7];
            res_crc_ok_q <= (crc_d == RESIDUE);
          end else if (w_nib_acc) begin
            crc_q                     <= crc_d;
            data_q[{cnt_q, 2'b00} +: 4] <= nib_in;
            cnt_q                     <= cnt_q + 2'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q     <= IDLE;
            crc_q       <= RESET_SEED;
            nib_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          nib_ready_q <= 1'b1;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign nib_ready  = nib_ready_q;
  assign res_valid  = res_valid_q;
  assign res_addr   = res_addr_q;
  assign res_endp   = res_endp_q;
  assign res_crc_ok = res_crc_ok_q;

`ifdef USB2_CRC5_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      err_cnt_q <= 8'h00;
    end else if (!clear && w_last && (crc_d != RESIDUE) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

`default_nettype wire
